// File: rtl/conv_tile_scheduler_pkg.sv
// Shared accelerator package for the convolution tile scheduler.
// Provides the dimension width, the scheduler state encoding and a small
// min helper used by the per-axis extent calculator.
package conv_tile_scheduler_pkg;

  localparam int DIM_W = 11;
  localparam int K_W   = 5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LW   = 3'd1,
    LIF  = 3'd2,
    SOF  = 3'd3,
    ADV  = 3'd4,
    FIN  = 3'd5
  } sched_state_t;

  function automatic logic [DIM_W-1:0] min_dim(input logic [DIM_W-1:0] a,
                                               input logic [DIM_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/conv_tile_scheduler_extent.sv
// tile_extent_calc: combinational extent of one tile along one axis.
//   ori   - tile origin on this axis
//   limit - number of output positions on this axis
//   tile  - maximum tile extent on this axis
//   halo  - extra input rows/cols needed around the tile (K-1, or 0)
//   ext   - min(tile, limit - ori) + halo
module tile_extent_calc
  import conv_tile_scheduler_pkg::*;
(
  input  logic [DIM_W-1:0] ori,
  input  logic [DIM_W-1:0] limit,
  input  logic [DIM_W-1:0] tile,
  input  logic [DIM_W-1:0] halo,
  output logic [DIM_W-1:0] ext
);

  logic [DIM_W-1:0] remain;

  assign remain = limit - ori;
  assign ext    = min_dim(tile, remain) + halo;

endmodule

// File: rtl/conv_tile_scheduler.sv
// conv_tile_scheduler: walks the output tiles of one convolution layer and
// issues load-weight / load-input / store-output commands to a data loader.
//   clk, rst            - clock, synchronous active-high reset
//   start               - one-cycle pulse that begins a layer (ignored while busy)
//   I, O, H, W, K       - layer geometry (H, W are input feature-map size)
//   tile_o/h/w          - maximum output-tile extents
//   loader_done         - loader completion pulse for the current command
//   load_weight, load_input, store_output - loader commands (one at a time)
//   Iori..Wext          - current tile description
//   busy, done, err     - status; done/err are one-cycle pulses
module conv_tile_scheduler
  import conv_tile_scheduler_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIM_W-1:0] I,
  input  logic [DIM_W-1:0] O,
  input  logic [DIM_W-1:0] H,
  input  logic [DIM_W-1:0] W,
  input  logic [K_W-1:0]   K,
  input  logic [DIM_W-1:0] tile_o,
  input  logic [DIM_W-1:0] tile_h,
  input  logic [DIM_W-1:0] tile_w,
  input  logic             loader_done,
  output logic             load_weight,
  output logic             load_input,
  output logic             store_output,
  output logic [DIM_W-1:0] Iori,
  output logic [DIM_W-1:0] Iext,
  output logic [DIM_W-1:0] Oori,
  output logic [DIM_W-1:0] Oext,
  output logic [DIM_W-1:0] Hori,
  output logic [DIM_W-1:0] Wori,
  output logic [DIM_W-1:0] Hext,
  output logic [DIM_W-1:0] Wext,
  output logic             busy,
  output logic             done,
  output logic             err
);

  sched_state_t state_reg, state_next;

  // gap_reg marks the cycle right after an accepted loader_done; the new
  // command is held low for that cycle so every command starts two cycles
  // after the previous completion.
  logic gap_reg;
  logic err_reg;

  logic [DIM_W-1:0] i_reg, o_reg, h_reg, w_reg;
  logic [DIM_W-1:0] to_reg, th_reg, tw_reg;
  logic [K_W-1:0]   k_reg;

  logic [DIM_W-1:0] o_ori_reg, h_ori_reg, w_ori_reg;
  logic [DIM_W-1:0] o_ori_next, h_ori_next, w_ori_next;

  logic [DIM_W-1:0] h_out, w_out, halo;
  logic [DIM_W:0]   o_sum, h_sum, w_sum;
  logic             o_wrap, h_wrap, w_wrap, last_tile;
  logic             cfg_ok, start_ok, start_bad, cmd_active, ld_ack, in_layer;

  logic [DIM_W-1:0] ax_ori   [3];
  logic [DIM_W-1:0] ax_limit [3];
  logic [DIM_W-1:0] ax_tile  [3];
  logic [DIM_W-1:0] ax_halo  [3];
  logic [DIM_W-1:0] ax_ext   [3];

  assign cfg_ok = (O != '0) && (I != '0) && (tile_o != '0) && (tile_h != '0) &&
                  (tile_w != '0) && (K != '0) &&
                  (DIM_W'(K) <= H) && (DIM_W'(K) <= W);
  assign start_ok  = start && (state_reg == IDLE) && cfg_ok;
  assign start_bad = start && (state_reg == IDLE) && !cfg_ok;

  assign h_out = h_reg - DIM_W'(k_reg) + DIM_W'(1);
  assign w_out = w_reg - DIM_W'(k_reg) + DIM_W'(1);
  assign halo  = DIM_W'(k_reg) - DIM_W'(1);

  assign cmd_active = ((state_reg == LW) || (state_reg == LIF) || (state_reg == SOF)) && !gap_reg;
  assign ld_ack     = cmd_active && loader_done;

  // Sums are one bit wider so a large step cannot wrap past the limit.
  assign w_sum  = {1'b0, w_ori_reg} + {1'b0, tw_reg};
  assign h_sum  = {1'b0, h_ori_reg} + {1'b0, th_reg};
  assign o_sum  = {1'b0, o_ori_reg} + {1'b0, to_reg};
  assign w_wrap = w_sum >= {1'b0, w_out};
  assign h_wrap = h_sum >= {1'b0, h_out};
  assign o_wrap = o_sum >= {1'b0, o_reg};
  assign last_tile = w_wrap && h_wrap && o_wrap;

  always_comb begin
    o_ori_next = o_ori_reg;
    h_ori_next = h_ori_reg;
    w_ori_next = w_ori_reg;
    if (!w_wrap) begin
      w_ori_next = w_sum[DIM_W-1:0];
    end else begin
      w_ori_next = '0;
      if (!h_wrap) begin
        h_ori_next = h_sum[DIM_W-1:0];
      end else begin
        h_ori_next = '0;
        o_ori_next = o_sum[DIM_W-1:0];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start_ok) state_next = LW;
      LW:   if (ld_ack) state_next = LIF;
      LIF:  if (ld_ack) state_next = SOF;
      SOF:  if (ld_ack) state_next = ADV;
      ADV: begin
        if (last_tile)             state_next = FIN;
        else if (w_wrap && h_wrap) state_next = LW;
        else                       state_next = LIF;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      gap_reg   <= 1'b0;
      err_reg   <= 1'b0;
      i_reg     <= '0;
      o_reg     <= '0;
      h_reg     <= '0;
      w_reg     <= '0;
      k_reg     <= '0;
      to_reg    <= '0;
      th_reg    <= '0;
      tw_reg    <= '0;
      o_ori_reg <= '0;
      h_ori_reg <= '0;
      w_ori_reg <= '0;
    end else begin
      state_reg <= state_next;
      gap_reg   <= ld_ack;
      err_reg   <= start_bad;
      if (start_ok) begin
        i_reg     <= I;
        o_reg     <= O;
        h_reg     <= H;
        w_reg     <= W;
        k_reg     <= K;
        to_reg    <= tile_o;
        th_reg    <= tile_h;
        tw_reg    <= tile_w;
        o_ori_reg <= '0;
        h_ori_reg <= '0;
        w_ori_reg <= '0;
      end else if ((state_reg == ADV) && !last_tile) begin
        o_ori_reg <= o_ori_next;
        h_ori_reg <= h_ori_next;
        w_ori_reg <= w_ori_next;
      end
    end
  end

  // Axis 0 = O (no halo), 1 = H, 2 = W.
  assign ax_ori[0]   = o_ori_reg;
  assign ax_ori[1]   = h_ori_reg;
  assign ax_ori[2]   = w_ori_reg;
  assign ax_limit[0] = o_reg;
  assign ax_limit[1] = h_out;
  assign ax_limit[2] = w_out;
  assign ax_tile[0]  = to_reg;
  assign ax_tile[1]  = th_reg;
  assign ax_tile[2]  = tw_reg;
  assign ax_halo[0]  = '0;
  assign ax_halo[1]  = halo;
  assign ax_halo[2]  = halo;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_axis
      tile_extent_calc u_calc (
        .ori   (ax_ori[gi]),
        .limit (ax_limit[gi]),
        .tile  (ax_tile[gi]),
        .halo  (ax_halo[gi]),
        .ext   (ax_ext[gi])
      );
    end
  endgenerate

  assign in_layer = (state_reg != IDLE);

  // Commands drop combinationally in the completion cycle.
  assign load_weight  = (state_reg == LW)  && !gap_reg && !loader_done;
  assign load_input   = (state_reg == LIF) && !gap_reg && !loader_done;
  assign store_output = (state_reg == SOF) && !gap_reg && !loader_done;

  assign busy = in_layer;
  assign done = (state_reg == FIN) || err_reg;
  assign err  = err_reg;

  // Tile fields read as zero outside a layer.
  assign Iori = '0;
  assign Iext = in_layer ? i_reg     : '0;
  assign Oori = in_layer ? o_ori_reg : '0;
  assign Hori = in_layer ? h_ori_reg : '0;
  assign Wori = in_layer ? w_ori_reg : '0;
  assign Oext = in_layer ? ax_ext[0] : '0;
  assign Hext = in_layer ? ax_ext[1] : '0;
  assign Wext = in_layer ? ax_ext[2] : '0;

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Self-checking bench for conv_tile_scheduler. A behavioural model expands
// each layer into the ordered list of commands with their tile fields; the
// stimulus plays a loader with random response latency and every cycle's
// outputs are compared against that list.
module tb_conv_tile_scheduler;

  logic        clk = 1'b0;
  logic        rst, start, loader_done;
  logic [10:0] I, O, H, W, tile_o, tile_h, tile_w;
  logic [4:0]  K;
  logic        load_weight, load_input, store_output;
  logic [10:0] Iori, Iext, Oori, Oext, Hori, Wori, Hext, Wext;
  logic        busy, done, err;

  conv_tile_scheduler dut (
    .clk(clk), .rst(rst), .start(start),
    .I(I), .O(O), .H(H), .W(W), .K(K),
    .tile_o(tile_o), .tile_h(tile_h), .tile_w(tile_w),
    .loader_done(loader_done),
    .load_weight(load_weight), .load_input(load_input), .store_output(store_output),
    .Iori(Iori), .Iext(Iext), .Oori(Oori), .Oext(Oext),
    .Hori(Hori), .Wori(Wori), .Hext(Hext), .Wext(Wext),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] C_NONE = 3'b000;
  localparam logic [2:0] C_LW   = 3'b100;
  localparam logic [2:0] C_LIF  = 3'b010;
  localparam logic [2:0] C_SOF  = 3'b001;

  typedef struct {
    logic [2:0] cmd;
    int oori, oext, hori, hext, wori, wext;
  } rec_t;

  rec_t exp_q[$];
  rec_t zr;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   sof_count = 0;
  logic prev_sof = 1'b0;
  int   cfg_i, cfg_o, cfg_h, cfg_w, cfg_k, cfg_to, cfg_th, cfg_tw;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Expand the current layer into its command sequence.
  task automatic build_model();
    rec_t r;
    int hout, wout;
    exp_q.delete();
    hout = cfg_h - cfg_k + 1;
    wout = cfg_w - cfg_k + 1;
    for (int o = 0; o < cfg_o; o += cfg_to) begin
      r.oori = o;
      r.oext = imin(cfg_to, cfg_o - o);
      r.cmd  = C_LW;
      r.hori = 0;
      r.wori = 0;
      r.hext = imin(cfg_th, hout) + cfg_k - 1;
      r.wext = imin(cfg_tw, wout) + cfg_k - 1;
      exp_q.push_back(r);
      for (int h = 0; h < hout; h += cfg_th) begin
        for (int w = 0; w < wout; w += cfg_tw) begin
          r.hori = h;
          r.wori = w;
          r.hext = imin(cfg_th, hout - h) + cfg_k - 1;
          r.wext = imin(cfg_tw, wout - w) + cfg_k - 1;
          r.cmd  = C_LIF;
          exp_q.push_back(r);
          r.cmd  = C_SOF;
          exp_q.push_back(r);
        end
      end
    end
  endtask

  task automatic drive_cfg();
    I = 11'(cfg_i); O = 11'(cfg_o); H = 11'(cfg_h); W = 11'(cfg_w);
    K = 5'(cfg_k);
    tile_o = 11'(cfg_to); tile_h = 11'(cfg_th); tile_w = 11'(cfg_tw);
  endtask

  task automatic set_cfg(input int i_, o_, h_, w_, k_, to_, th_, tw_);
    cfg_i = i_; cfg_o = o_; cfg_h = h_; cfg_w = w_; cfg_k = k_;
    cfg_to = to_; cfg_th = th_; cfg_tw = tw_;
  endtask

  // Check one cycle of outputs at the falling edge, then move to just after
  // the next rising edge.
  task automatic step(input logic [2:0] ecmd, input bit ebusy, input bit edone,
                      input bit eerr, input bit chk_f, input rec_t r, input int eiext);
    logic [2:0] cmds;
    @(negedge clk);
    cmds = {load_weight, load_input, store_output};
    if (store_output && !prev_sof) sof_count++;
    prev_sof = store_output;
    chk("one_cmd", int'($countones(cmds) <= 1), 1);
    chk("cmd", int'(cmds), int'(ecmd));
    chk("busy", int'(busy), int'(ebusy));
    chk("done", int'(done), int'(edone));
    chk("err", int'(err), int'(eerr));
    if (chk_f) begin
      chk("Iori", int'(Iori), 0);
      chk("Iext", int'(Iext), eiext);
      chk("Oori", int'(Oori), r.oori);
      chk("Oext", int'(Oext), r.oext);
      chk("Hori", int'(Hori), r.hori);
      chk("Hext", int'(Hext), r.hext);
      chk("Wori", int'(Wori), r.wori);
      chk("Wext", int'(Wext), r.wext);
    end
    @(posedge clk);
    #1;
  endtask

  // Run one layer through the DUT. abort_idx >= 0 pulses rst while that
  // command is high; noisy adds starts while busy and spurious loader_done
  // in the advance cycle.
  task automatic run_layer(input int abort_idx, input bit noisy);
    rec_t r;
    int d;
    build_model();
    drive_cfg();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      r = exp_q[k];
      d = $urandom_range(1, 3);
      if (k == abort_idx) begin
        step(r.cmd, 1, 0, 0, 1, r, cfg_i);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(C_NONE, 0, 0, 0, 1, zr, 0);
        $display("layer O=%0d H=%0d W=%0d K=%0d aborted by rst at cmd %0d", cfg_o, cfg_h, cfg_w, cfg_k, k);
        return;
      end
      for (int j = 0; j < d; j++) begin
        if (noisy && ($urandom_range(0, 3) == 0)) begin
          start = 1'b1;
          O = 11'($urandom_range(1, 9));
        end
        step(r.cmd, 1, 0, 0, 1, r, cfg_i);
        start = 1'b0;
        O = 11'(cfg_o);
      end
      loader_done = 1'b1;
      step(C_NONE, 1, 0, 0, 1, r, cfg_i);
      loader_done = 1'b0;
      if (noisy && (r.cmd == C_SOF) && ($urandom_range(0, 1) == 0)) loader_done = 1'b1;
      step(C_NONE, 1, 0, 0, 0, r, cfg_i);
      loader_done = 1'b0;
    end
    step(C_NONE, 1, 1, 0, 0, zr, 0);
    step(C_NONE, 0, 0, 0, 1, zr, 0);
    $display("layer I=%0d O=%0d H=%0d W=%0d K=%0d tiles=%0d/%0d/%0d commands=%0d",
             cfg_i, cfg_o, cfg_h, cfg_w, cfg_k, cfg_to, cfg_th, cfg_tw, exp_q.size());
  endtask

  task automatic run_bad(input string nm);
    drive_cfg();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    step(C_NONE, 0, 1, 1, 1, zr, 0);
    step(C_NONE, 0, 0, 0, 1, zr, 0);
    $display("bad config %s: err pulse checked", nm);
  endtask

  initial begin
    int n_lw, n_lif, n_sof, sof0;
    zr = '{cmd: C_NONE, oori: 0, oext: 0, hori: 0, hext: 0, wori: 0, wext: 0};
    rst = 1'b1; start = 1'b0; loader_done = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
    drive_cfg();
    @(posedge clk);
    #1;
    step(C_NONE, 0, 0, 0, 1, zr, 0);
    rst = 1'b0;
    step(C_NONE, 0, 0, 0, 1, zr, 0);

    // Basic layer: pin the model, then run it through the DUT.
    set_cfg(5, 4, 6, 6, 3, 2, 2, 2);
    build_model();
    n_lw = 0; n_lif = 0; n_sof = 0;
    foreach (exp_q[q]) begin
      if (exp_q[q].cmd == C_LW)  n_lw++;
      if (exp_q[q].cmd == C_LIF) n_lif++;
      if (exp_q[q].cmd == C_SOF) n_sof++;
    end
    chk("model_lw_count", n_lw, 2);
    chk("model_lif_count", n_lif, 8);
    chk("model_sof_count", n_sof, 8);
    chk("model_second_lw", int'(exp_q[9].cmd), int'(C_LW));
    chk("model_second_oori", exp_q[9].oori, 2);
    chk("model_hext", exp_q[3].hext, 4);
    chk("model_wori", exp_q[3].wori, 2);
    sof0 = sof_count;
    run_layer(-1, 0);
    chk("dut_sof_count_basic", sof_count - sof0, 8);

    // Same layer with starts while busy and spurious loader_done in ADV.
    sof0 = sof_count;
    run_layer(-1, 1);
    chk("dut_sof_count_noisy", sof_count - sof0, 8);

    // Edge tiles.
    set_cfg(7, 3, 7, 7, 3, 2, 2, 2);
    build_model();
    chk("model_oext_first", exp_q[0].oext, 2);
    chk("model_oext_last", exp_q[19].oext, 1);
    chk("model_hext_h0", exp_q[1].hext, 4);
    chk("model_hori_h2", exp_q[7].hori, 2);
    chk("model_hext_h2", exp_q[7].hext, 4);
    chk("model_hori_h4", exp_q[13].hori, 4);
    chk("model_hext_h4", exp_q[13].hext, 3);
    sof0 = sof_count;
    run_layer(-1, 1);
    chk("dut_sof_count_edge", sof_count - sof0, 18);

    // Bad configurations.
    set_cfg(5, 4, 6, 6, 8, 2, 2, 2); run_bad("K>H");
    set_cfg(5, 0, 6, 6, 3, 2, 2, 2); run_bad("O=0");
    set_cfg(0, 4, 6, 6, 3, 2, 2, 2); run_bad("I=0");
    set_cfg(5, 4, 6, 6, 3, 2, 0, 2); run_bad("tile_h=0");
    set_cfg(5, 4, 6, 6, 0, 2, 2, 2); run_bad("K=0");
    set_cfg(5, 4, 9, 4, 5, 2, 2, 2); run_bad("K>W");

    // Reset during SOF of the third tile, then a fresh start from origin 0.
    set_cfg(5, 4, 6, 6, 3, 2, 2, 2);
    run_layer(6, 0);
    run_layer(-1, 0);

    // Start coinciding with reset is dropped.
    drive_cfg();
    rst = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    step(C_NONE, 0, 0, 0, 1, zr, 0);
    step(C_NONE, 0, 0, 0, 1, zr, 0);

    // Random layers.
    for (int n = 0; n < 8; n++) begin
      int kk;
      kk = $urandom_range(1, 4);
      set_cfg($urandom_range(1, 2047), $urandom_range(1, 6),
              kk + $urandom_range(0, 6), kk + $urandom_range(0, 6), kk,
              $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4));
      run_layer(-1, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
